inst_mem_responder: RTL and testbench

//  Program-memory responder on the far side of the control unit's instruction-fetch interface.

---
 rtl/inst_mem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_inst_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//
// Program-memory responder for the control unit's instruction-fetch port.
// It accepts one fetch at a time. After a fixed number of wait states it
// returns the 32-bit word using a valid/ack handshake. A separate write-only
// load port fills program memory at any time.
//
// Optional feature macro: INST_MEM_PARITY_EN
//   Defined   : one even-parity bit is stored per word. A parity mismatch on a
//               fetch of a loaded, in-range word raises fetch_err. A sticky
//               parity_err output is added.
//   Undefined : no parity storage and no parity_err port.
//
// Ports
//   clk          in   1       rising-edge clock
//   sys_rst_n    in   1       asynchronous active-low reset
//   fetch_req    in   1       fetch request, accepted when fetch_ready is high
//   fetch_addr   in   ADDR_W  word address to fetch
//   fetch_ready  out  1       idle, can accept a request
//   fetch_valid  out  1       response valid, held until fetch_ack
//   fetch_data   out  32      instruction word (0 if unloaded or out of range)
//   fetch_err    out  1       error qualifier, meaningful with fetch_valid
//   fetch_ack    in   1       requester consumed the response
//   load_we      in   1       program-load write strobe
//   load_addr    in   5       program-load word address
//   load_data    in   32      program-load data
//   parity_err   out  1       (INST_MEM_PARITY_EN only) sticky parity error
// ---------------------------------------------------------------------------
module inst_mem_responder #(
   parameter int DEPTH       = 32,
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [31:0]       fetch_data,
   output logic              fetch_err,
   input  logic              fetch_ack,
   input  logic              load_we,
   input  logic [4:0]        load_addr,
   input  logic [31:0]       load_data
`ifdef INST_MEM_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              accept;

   logic [IDX_W-1:0]  load_idx;
   logic [IDX_W-1:0]  fetch_idx;
   logic              load_in_range;
   logic              fetch_in_range;
   logic [DEPTH-1:0]  load_hit;
   logic              load_wr;
   logic [DEPTH-1:0]  loaded_reg;

   logic [31:0]       mem_array [DEPTH];
   logic [31:0]       rd_word_reg;
   logic              hit_reg;      // captured: in range and loaded
   logic              oor_reg;      // captured: address out of range

   assign load_idx       = load_addr[IDX_W-1:0];
   assign fetch_idx      = fetch_addr[IDX_W-1:0];
   assign fetch_in_range = (fetch_addr < ADDR_W'(DEPTH));

   // The 5-bit load address cannot exceed a 32-word memory. The range check
   // is only built when it can actually fail.
   generate
      if (DEPTH >= 32) begin : g_load_full
         assign load_in_range = 1'b1;
      end else begin : g_load_part
         assign load_in_range = (load_addr < 5'(DEPTH));
      end
   endgenerate

   // Per-word write decode. It drives both the loaded bitmap and the write enable.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_load_dec
         assign load_hit[gi] = load_we && load_in_range && (load_idx == IDX_W'(gi));
      end
   endgenerate

   assign load_wr = |load_hit;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // WAIT lasts WAIT_CYCLES+1 clocks. Accept-to-valid latency is therefore
   // WAIT_CYCLES+1 edges for every setting, including zero.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (fetch_req) begin
               accept     = 1'b1;
               cnt_next   = 4'd0;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_reg == WAIT_LAST) begin
               state_next = S_RESP;
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         S_RESP: begin
            if (fetch_ack) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign fetch_ready = (state_reg == S_IDLE);
   assign fetch_valid = (state_reg == S_RESP);

   // ---------------- status capture (reset) ----------------
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         loaded_reg <= '0;
         hit_reg    <= 1'b0;
         oor_reg    <= 1'b0;
      end else begin
         loaded_reg <= loaded_reg | load_hit;
         // Uses the pre-edge bitmap, so a same-edge load is not yet visible.
         if (accept) begin
            hit_reg <= fetch_in_range && loaded_reg[fetch_idx];
            oor_reg <= !fetch_in_range;
         end
      end
   end

   // ---------------- storage (no reset, RAM-inferable) ----------------
   // The registered read takes the old word when a load hits the same
   // address on the accept edge.
   always_ff @(posedge clk) begin
      if (load_wr) begin
         mem_array[load_idx] <= load_data;
      end
      if (accept) begin
         rd_word_reg <= mem_array[fetch_idx];
      end
   end

   assign fetch_data = hit_reg ? rd_word_reg : 32'h0;

`ifdef INST_MEM_PARITY_EN
   logic              par_array [DEPTH];
   logic              rd_par_reg;
   logic              par_bad;
   logic              parity_err_reg;

   always_ff @(posedge clk) begin
      if (load_wr) begin
         par_array[load_idx] <= ^load_data;
      end
      if (accept) begin
         rd_par_reg <= par_array[fetch_idx];
      end
   end

   // Unloaded words have no meaningful parity and are never flagged.
   assign par_bad = hit_reg && ((^rd_word_reg) != rd_par_reg);

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         parity_err_reg <= 1'b0;
      end else if ((state_reg == S_RESP) && par_bad) begin
         parity_err_reg <= 1'b1;
      end
   end

   assign parity_err = parity_err_reg;
   assign fetch_err  = oor_reg | par_bad;
`else
   assign fetch_err  = oor_reg;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

   logic        clk = 1'b0;
   logic        sys_rst_n;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_err;
   logic        fetch_ack;
   logic        load_we;
   logic [4:0]  load_addr;
   logic [31:0] load_data;
`ifdef INST_MEM_PARITY_EN
   logic        parity_err;
`endif

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   inst_mem_responder #(
      .DEPTH(32),
      .ADDR_W(16),
      .WAIT_CYCLES(2)
   ) dut (
      .clk(clk),
      .sys_rst_n(sys_rst_n),
      .fetch_req(fetch_req),
      .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid),
      .fetch_data(fetch_data),
      .fetch_err(fetch_err),
      .fetch_ack(fetch_ack),
      .load_we(load_we),
      .load_addr(load_addr),
      .load_data(load_data)
`ifdef INST_MEM_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] a, input logic [31:0] d);
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_we   = 1'b0;
   endtask

   // Issue a fetch, count edges until valid (bounded), optionally acknowledge.
   task automatic do_fetch(input logic [15:0] a, input bit ack_it,
                           output int lat, output logic [31:0] d, output logic e);
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      fetch_req  = 1'b0;
      lat = 0;
      while (fetch_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      d = fetch_data;
      e = fetch_err;
      if (ack_it) begin
         fetch_ack = 1'b1;
         tick();
         fetch_ack = 1'b0;
      end
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0;
      tick();
      tick();
      nvec++; if (fetch_ready !== 1'b1) begin nmis++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
      nvec++; if (fetch_valid !== 1'b0) begin nmis++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
      nvec++; if (fetch_data !== 32'h0) begin nmis++; $display("FAIL reset_data got=%h exp=0", fetch_data); end
      nvec++; if (fetch_err !== 1'b0) begin nmis++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
`ifdef INST_MEM_PARITY_EN
      nvec++; if (parity_err !== 1'b0) begin nmis++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
`endif
      sys_rst_n = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_basic_fetch;
      int lat; logic [31:0] d; logic e;
      do_load(5'd3, 32'h0848_0005);
      do_fetch(16'd3, 1'b1, lat, d, e);
      nvec++; if (lat != 3) begin nmis++; $display("FAIL basic_latency got=%0d exp=3", lat); end
      nvec++; if (d !== 32'h0848_0005) begin nmis++; $display("FAIL basic_data got=%h exp=08480005", d); end
      nvec++; if (e !== 1'b0) begin nmis++; $display("FAIL basic_err got=%b exp=0", e); end
      nvec++; if (fetch_ready !== 1'b1) begin nmis++; $display("FAIL basic_ready_after_ack got=%b exp=1", fetch_ready); end
      nvec++; if (fetch_valid !== 1'b0) begin nmis++; $display("FAIL basic_valid_after_ack got=%b exp=0", fetch_valid); end
      $display("test_basic_fetch addr=3 data=%h err=%b lat=%0d", d, e, lat);
   endtask

   task automatic test_unloaded_and_range;
      int lat; logic [31:0] d; logic e;
      logic [15:0] addrs [4];
      logic        exp_e [4];
      addrs[0] = 16'd7;  exp_e[0] = 1'b0;
      addrs[1] = 16'd40; exp_e[1] = 1'b1;
      addrs[2] = 16'd31; exp_e[2] = 1'b0;
      addrs[3] = 16'd32; exp_e[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_fetch(addrs[i], 1'b1, lat, d, e);
         nvec++; if (d !== 32'h0) begin nmis++; $display("FAIL range_data addr=%0d got=%h exp=0", addrs[i], d); end
         nvec++; if (e !== exp_e[i]) begin nmis++; $display("FAIL range_err addr=%0d got=%b exp=%b", addrs[i], e, exp_e[i]); end
         $display("test_unloaded_and_range addr=%0d data=%h err=%b", addrs[i], d, e);
      end
   endtask

   task automatic test_hold_resp;
      int lat; logic [31:0] d; logic e;
      bit bad_valid, bad_data, bad_ready, late_valid;
      bad_valid = 0; bad_data = 0; bad_ready = 0; late_valid = 0;
      do_fetch(16'd3, 1'b0, lat, d, e);
      for (int i = 0; i < 5; i++) begin
         fetch_req  = (i % 2 == 0);
         fetch_addr = 16'd9;
         tick();
         if (fetch_valid !== 1'b1) bad_valid = 1;
         if (fetch_data !== 32'h0848_0005) bad_data = 1;
         if (fetch_ready !== 1'b0) bad_ready = 1;
      end
      fetch_req = 1'b0;
      nvec++; if (bad_valid) begin nmis++; $display("FAIL hold_valid got=dropped exp=held"); end
      nvec++; if (bad_data) begin nmis++; $display("FAIL hold_data got=changed exp=08480005"); end
      nvec++; if (bad_ready) begin nmis++; $display("FAIL hold_ready got=1 exp=0"); end
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (fetch_valid === 1'b1) late_valid = 1;
      end
      nvec++; if (late_valid) begin nmis++; $display("FAIL hold_no_queue got=valid exp=idle"); end
      $display("test_hold_resp data=%h", d);
   endtask

   task automatic test_load_collision;
      int lat; logic [31:0] d; logic e;
      do_load(5'd5, 32'hAAAA_0000);
      load_we    = 1'b1;
      load_addr  = 5'd5;
      load_data  = 32'h1234_5678;
      fetch_req  = 1'b1;
      fetch_addr = 16'd5;
      tick();
      load_we   = 1'b0;
      fetch_req = 1'b0;
      lat = 0;
      while (fetch_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      nvec++; if (lat != 3) begin nmis++; $display("FAIL collide_latency got=%0d exp=3", lat); end
      nvec++; if (fetch_data !== 32'hAAAA_0000) begin nmis++; $display("FAIL collide_old_data got=%h exp=aaaa0000", fetch_data); end
      $display("test_load_collision first data=%h", fetch_data);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      do_fetch(16'd5, 1'b1, lat, d, e);
      nvec++; if (d !== 32'h1234_5678) begin nmis++; $display("FAIL collide_new_data got=%h exp=12345678", d); end
      $display("test_load_collision second data=%h", d);
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] d; logic e;
      do_load(5'd4, 32'hDEAD_BEEF);
      do_fetch(16'd3, 1'b1, lat, d, e);
      nvec++; if (d !== 32'h0848_0005) begin nmis++; $display("FAIL b2b_first got=%h exp=08480005", d); end
      do_fetch(16'd4, 1'b1, lat, d, e);
      nvec++; if (d !== 32'hDEAD_BEEF) begin nmis++; $display("FAIL b2b_second got=%h exp=deadbeef", d); end
      nvec++; if (lat != 3) begin nmis++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
      $display("test_back_to_back data=%h lat=%0d", d, lat);
   endtask

   task automatic test_reset_midflight;
      int lat; logic [31:0] d; logic e;
      bit late_valid;
      late_valid = 0;
      fetch_req  = 1'b1;
      fetch_addr = 16'd3;
      tick();
      fetch_req = 1'b0;
      tick();
      #1 sys_rst_n = 1'b0;
      #1;
      nvec++; if (fetch_ready !== 1'b1) begin nmis++; $display("FAIL midrst_ready got=%b exp=1", fetch_ready); end
      nvec++; if (fetch_valid !== 1'b0) begin nmis++; $display("FAIL midrst_valid got=%b exp=0", fetch_valid); end
      nvec++; if (fetch_data !== 32'h0) begin nmis++; $display("FAIL midrst_data got=%h exp=0", fetch_data); end
      #1 sys_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (fetch_valid === 1'b1) late_valid = 1;
      end
      nvec++; if (late_valid) begin nmis++; $display("FAIL midrst_no_valid got=valid exp=none"); end
      do_fetch(16'd3, 1'b1, lat, d, e);
      nvec++; if (d !== 32'h0) begin nmis++; $display("FAIL midrst_cleared_data got=%h exp=0", d); end
      nvec++; if (e !== 1'b0) begin nmis++; $display("FAIL midrst_cleared_err got=%b exp=0", e); end
      $display("test_reset_midflight readback=%h err=%b", d, e);
   endtask

`ifdef INST_MEM_PARITY_EN
   task automatic test_parity;
      int lat; logic [31:0] d; logic e;
      do_load(5'd2, 32'h0000_00FF);
      do_load(5'd6, 32'h0000_0003);
      do_fetch(16'd2, 1'b1, lat, d, e);
      nvec++; if (e !== 1'b0) begin nmis++; $display("FAIL par_clean_err got=%b exp=0", e); end
      nvec++; if (parity_err !== 1'b0) begin nmis++; $display("FAIL par_clean_sticky got=%b exp=0", parity_err); end
      dut.mem_array[2] = 32'h0000_00FE;
      do_fetch(16'd2, 1'b1, lat, d, e);
      nvec++; if (d !== 32'h0000_00FE) begin nmis++; $display("FAIL par_bad_data got=%h exp=000000fe", d); end
      nvec++; if (e !== 1'b1) begin nmis++; $display("FAIL par_bad_err got=%b exp=1", e); end
      do_fetch(16'd6, 1'b1, lat, d, e);
      nvec++; if (e !== 1'b0) begin nmis++; $display("FAIL par_after_err got=%b exp=0", e); end
      nvec++; if (parity_err !== 1'b1) begin nmis++; $display("FAIL par_sticky got=%b exp=1", parity_err); end
      sys_rst_n = 1'b0;
      tick();
      nvec++; if (parity_err !== 1'b0) begin nmis++; $display("FAIL par_reset got=%b exp=0", parity_err); end
      sys_rst_n = 1'b1;
      tick();
      $display("test_parity done");
   endtask
`endif

   initial begin
      sys_rst_n  = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = 16'd0;
      fetch_ack  = 1'b0;
      load_we    = 1'b0;
      load_addr  = 5'd0;
      load_data  = 32'h0;
      test_reset();
      test_basic_fetch();
      test_unloaded_and_range();
      test_hold_resp();
      test_load_collision();
      test_back_to_back();
      test_reset_midflight();
`ifdef INST_MEM_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
